// File: rtl/arbitro_botoes_pkg.sv
// arbitro_botoes_pkg: shared state encoding, default button count and index width helper.
package arbitro_botoes_pkg;
    typedef enum logic [1:0] {OCIOSO, OFERTA, ESPERA} estado_t;
    localparam int N_BOTOES_PADRAO = 8;
    function automatic int largura_indice(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/seletor_round_robin.sv
// seletor_round_robin: first set bit of mascara at or after ponteiro, wrapping around.
module seletor_round_robin
    import arbitro_botoes_pkg::*;
#(
    parameter int N = N_BOTOES_PADRAO
) (
    input  logic [N-1:0]                   mascara,
    input  logic [largura_indice(N)-1:0]   ponteiro,
    output logic                           achou,
    output logic [largura_indice(N)-1:0]   indice
);
    localparam int W = largura_indice(N);
    logic [W:0]   soma;
    logic [W-1:0] j;
    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        achou = 1'b0;
        indice = '0;
        soma = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            soma = {1'b0, ponteiro} + (W + 1)'(i);
            j = (soma >= (W + 1)'(N)) ? W'(soma - (W + 1)'(N)) : soma[W-1:0];
            if (mascara[j]) begin
                achou = 1'b1;
                indice = j;
            end
        end
    end
endmodule

// File: rtl/arbitro_botoes.sv
// arbitro_botoes: latches button edges as pending and serializes them round-robin
// into a paced valid/ready command stream.
module arbitro_botoes
    import arbitro_botoes_pkg::*;
#(
    parameter int N_BOTOES = N_BOTOES_PADRAO,
    parameter int HOLDOFF  = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_BOTOES-1:0]                 edge_detected,
    input  logic                                habilita,
    input  logic                                limpa,
    output logic                                cmd_valid,
    input  logic                                cmd_ready,
    output logic [largura_indice(N_BOTOES)-1:0] cmd_botao,
    output logic [N_BOTOES-1:0]                 pendentes,
    output logic                                overrun
);
    localparam int W  = largura_indice(N_BOTOES);
    localparam int CW = largura_indice(HOLDOFF + 1);
    estado_t             estado;
    logic [W-1:0]        ponteiro, sel_indice;
    logic [CW-1:0]       contador;
    logic                sel_achou, aceite;
    logic [N_BOTOES-1:0] limpar, novos;
    assign aceite = cmd_valid & cmd_ready;
    assign limpar = aceite ? N_BOTOES'(1) << cmd_botao : '0;
    assign novos  = edge_detected & {N_BOTOES{habilita}};
    seletor_round_robin #(.N(N_BOTOES)) u_seletor (
        .mascara  (pendentes),
        .ponteiro (ponteiro),
        .achou    (sel_achou),
        .indice   (sel_indice)
    );
    // A new edge on the button being accepted re-sets its bit: that is a second press.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            cmd_valid <= 1'b0;
            cmd_botao <= '0;
            pendentes <= '0;
            overrun   <= 1'b0;
            ponteiro  <= '0;
            contador  <= '0;
        end else if (limpa) begin
            estado    <= OCIOSO;
            cmd_valid <= 1'b0;
            pendentes <= '0;
            overrun   <= 1'b0;
            contador  <= '0;
        end else begin
            pendentes <= (pendentes & ~limpar) | novos;
            overrun   <= |(novos & pendentes & ~limpar);
            case (estado)
                OCIOSO: if (sel_achou) begin
                    cmd_botao <= sel_indice;
                    cmd_valid <= 1'b1;
                    estado    <= OFERTA;
                end
                OFERTA: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    ponteiro  <= (cmd_botao == W'(N_BOTOES - 1)) ? '0 : cmd_botao + 1'b1;
                    contador  <= '0;
                    estado    <= (HOLDOFF == 0) ? OCIOSO : ESPERA;
                end
                ESPERA: if (contador == CW'(HOLDOFF - 1)) estado <= OCIOSO;
                        else contador <= contador + 1'b1;
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule
